// File: rtl/ov_cfg_seq.sv
// Camera configuration sequencer: walks a register table and issues one SCCB
// write per entry, with end-of-table marker, settle gap and start timeout.
module ov_cfg_seq #(
   parameter logic [7:0]  CHIP_ADDR      = 8'h42,
   parameter int unsigned NUM_REGS       = 64,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic [7:0]  sccb_addr,
   output logic [7:0]  sccb_subaddr,
   output logic [7:0]  sccb_wdata,
   output logic        sccb_start,
   input  logic        sccb_busy,
   input  logic        sccb_end,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  count
);

   localparam int unsigned TW = 16;
   localparam logic [7:0]    LAST_IDX     = 8'(NUM_REGS - 1);
   localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0]   END_MARKER   = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE, FETCH, LATCH, ISSUE, WAIT_BUSY, WAIT_END, SETTLE, FINISH
   } state_t;

   state_t        state;
   logic [7:0]    idx;
   logic [TW-1:0] timer;
   logic [7:0]    count_inc;

   assign count_inc = (count == 8'hFF) ? count : count + 8'd1;

   // rom_addr is loaded on entry to FETCH so a registered table read lands in LATCH.
   // timer is shared: busy-rise timeout in WAIT_BUSY, gap length in SETTLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= 8'd0;
         timer        <= '0;
         rom_addr     <= 8'd0;
         sccb_addr    <= CHIP_ADDR;
         sccb_subaddr <= 8'd0;
         sccb_wdata   <= 8'd0;
         sccb_start   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         count        <= 8'd0;
      end else begin
         sccb_start <= 1'b0;
         done       <= 1'b0;
         sccb_addr  <= CHIP_ADDR;
         case (state)
            IDLE: begin
               if (start) begin
                  idx      <= 8'd0;
                  rom_addr <= 8'd0;
                  count    <= 8'd0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               state <= LATCH;
            end
            LATCH: begin
               if (rom_data == END_MARKER) begin
                  state <= FINISH;
               end else begin
                  sccb_subaddr <= rom_data[15:8];
                  sccb_wdata   <= rom_data[7:0];
                  sccb_start   <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               // An end with no visible busy phase still counts as a completed write.
               if (sccb_end) begin
                  count <= count_inc;
                  timer <= '0;
                  state <= SETTLE;
               end else if (sccb_busy) begin
                  state <= WAIT_END;
               end else if (timer == TIMEOUT_LAST) begin
                  error <= 1'b1;
                  state <= FINISH;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_END: begin
               if (sccb_end) begin
                  count <= count_inc;
                  timer <= '0;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (timer == SETTLE_LAST) begin
                  if (idx == LAST_IDX) begin
                     state <= FINISH;
                  end else begin
                     idx      <= idx + 8'd1;
                     rom_addr <= idx + 8'd1;
                     state    <= FETCH;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               done  <= ~error;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov_cfg_seq.sv
// Bench for ov_cfg_seq: table-driven runs against a behavioural SCCB master
// and ROM, with a payload scoreboard and hand sequences for reset and spam.
module tb_ov_cfg_seq;

   localparam logic [7:0] CHIP = 8'h42;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [7:0]  sccb_addr, sccb_subaddr, sccb_wdata;
   logic        sccb_start, sccb_busy, sccb_end;
   logic        busy, done, error;
   logic [7:0]  count;

   always #5 clk = ~clk;

   ov_cfg_seq #(
      .CHIP_ADDR(CHIP), .NUM_REGS(4), .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .sccb_addr(sccb_addr), .sccb_subaddr(sccb_subaddr), .sccb_wdata(sccb_wdata),
      .sccb_start(sccb_start), .sccb_busy(sccb_busy), .sccb_end(sccb_end),
      .busy(busy), .done(done), .error(error), .count(count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SCCB model modes: 0 busy at +2 / end at +20, 1 silent, 2 end at +3 without busy
   logic [15:0] rom [4];
   logic [15:0] exp_q [$];
   int  mode = 0;
   int  cyc = 0;
   int  t = 0;
   bit  act = 0;
   int  n_starts = 0, n_dones = 0, max_addr = 0;
   int  last_end = -1, start_cyc = 0;
   logic err_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : monitor_and_model
      logic [15:0] e;
      if (sccb_start) begin
         n_starts++;
         start_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got subaddr/data %02h/%02h with no write expected",
                     sccb_subaddr, sccb_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_payload", {16'd0, sccb_subaddr, sccb_wdata}, {16'd0, e});
         end
         check("sccb_addr", {24'd0, sccb_addr}, {24'd0, CHIP});
         if (last_end >= 0) check("end_to_start_gap", cyc - last_end, 4);
      end
      if (done) n_dones++;
      if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (error && !err_prev) check("timeout_latency", cyc - start_cyc, 9);
      err_prev = error;

      rom_data = (rom_addr < 8'd4) ? rom[rom_addr[1:0]] : 16'hFFFF;
      if (sccb_start) begin
         act = 1;
         t = 0;
      end else if (act) begin
         t++;
      end
      sccb_busy = act && mode == 0 && t >= 2 && t < 20;
      sccb_end  = act && ((mode == 0 && t == 20) || (mode == 2 && t == 3));
      if (sccb_end) last_end = cyc;
      if (act && t >= 20) act = 0;
   end

   typedef struct {
      logic [63:0] tbl;
      int mode;
      int exp_starts;
      int exp_count;
      int exp_err;
      int exp_dones;
      int exp_max;
      bit spam;
   } vec_t;

   vec_t vecs [6];

   task automatic load_table(input logic [63:0] tbl);
      for (int i = 0; i < 4; i++) rom[i] = tbl[63-16*i -: 16];
   endtask

   task automatic push_expected();
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         if (rom[i] == 16'hFFFF) break;
         exp_q.push_back(rom[i]);
         if (mode == 1) break;
      end
   endtask

   task automatic run_case(input vec_t v, input int id);
      int k;
      load_table(v.tbl);
      mode = v.mode;
      push_expected();
      n_starts = 0; n_dones = 0; max_addr = 0; last_end = -1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check($sformatf("c%0d_busy_on_accept", id), {31'd0, busy}, 1);
      check($sformatf("c%0d_error_cleared", id), {31'd0, error}, 0);
      check($sformatf("c%0d_count_cleared", id), {24'd0, count}, 0);
      k = 0;
      while (busy && k < 3000) begin
         @(negedge clk);
         start = v.spam && busy && (k % 5 == 0);
         k++;
      end
      start = 1'b0;
      if (k >= 3000) begin
         checks++;
         errors++;
         $display("FAIL c%0d_run_timeout: busy still %0b after %0d cycles", id, busy, k);
      end
      repeat (3) @(negedge clk);
      check($sformatf("c%0d_starts", id), n_starts, v.exp_starts);
      check($sformatf("c%0d_count", id), {24'd0, count}, v.exp_count);
      check($sformatf("c%0d_error", id), {31'd0, error}, v.exp_err);
      check($sformatf("c%0d_dones", id), n_dones, v.exp_dones);
      check($sformatf("c%0d_max_rom_addr", id), max_addr, v.exp_max);
      check($sformatf("c%0d_queue_left", id), exp_q.size(), 0);
      check($sformatf("c%0d_busy_idle", id), {31'd0, busy}, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rom_addr"}, {24'd0, rom_addr}, 0);
      check({tag, "_sccb_addr"}, {24'd0, sccb_addr}, {24'd0, CHIP});
      check({tag, "_subaddr"}, {24'd0, sccb_subaddr}, 0);
      check({tag, "_wdata"}, {24'd0, sccb_wdata}, 0);
      check({tag, "_sccb_start"}, {31'd0, sccb_start}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_done"}, {31'd0, done}, 0);
      check({tag, "_error"}, {31'd0, error}, 0);
      check({tag, "_count"}, {24'd0, count}, 0);
   endtask

   initial begin
      int k, s_before, d_before;
      vecs[0] = '{64'h0012_0A80_1040_3A04, 0, 4, 4, 0, 1, 3, 1'b0};
      vecs[1] = '{64'h0012_0A80_FFFF_3A04, 0, 2, 2, 0, 1, 2, 1'b0};
      vecs[2] = '{64'h0012_0A80_1040_3A04, 1, 1, 0, 1, 0, 0, 1'b0};
      vecs[3] = '{64'hFFFF_0A80_1040_3A04, 0, 0, 0, 0, 1, 0, 1'b0};
      vecs[4] = '{64'h5511_6622_FFFF_0000, 2, 2, 2, 0, 1, 2, 1'b0};
      vecs[5] = '{64'h0012_0A80_1040_3A04, 0, 4, 4, 0, 1, 3, 1'b1};

      load_table(vecs[0].tbl);
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_case(vecs[i], i);
         repeat (5) @(negedge clk);
      end

      // Reset during the WAIT_END of the second write
      load_table(vecs[0].tbl);
      mode = 0;
      push_expected();
      n_starts = 0; n_dones = 0; last_end = -1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      k = 0;
      while (!(n_starts == 2 && sccb_busy) && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) begin
         checks++;
         errors++;
         $display("FAIL midreset_reach_write2: got %0d starts, required 2", n_starts);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      s_before = n_starts;
      d_before = n_dones;
      @(negedge clk);
      check_reset_values("midreset");
      reset = 1'b0;
      exp_q.delete();
      repeat (40) @(negedge clk);
      check("midreset_no_more_starts", n_starts, s_before);
      check("midreset_no_done", n_dones, d_before);
      check("midreset_idle", {31'd0, busy}, 0);
      run_case(vecs[0], 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
